hazard_ctrl: RTL and testbench

Parametrised hazard detection and forwarding controller for the pipelined MIPS core. It tracks in-flight destination registers across DEPTH post-decode stages (X, M, …, WB) and compares them against the decode-stage source registers. It drives forwarding selects into the DX buffer, stall signals into IF/FD, and flush signals into FD/DX on a taken branch or jump. It replaces the fixed two-source, three-stage hazard unit with one that is generic in register count, source-port count, pipeline depth and branch-resolve stage.

---
 rtl/hazard_ctrl_pkg.sv | 24 ++
 rtl/hazard_ctrl_if.sv | 32 +++
 rtl/hazard_ctrl_src_match.sv | 37 +++
 rtl/hazard_ctrl.sv | 101 ++++++++++
 tb/tb_hazard_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: in-flight pipeline entry record and
// forwarding-select encoding (0 = register file, k+1 = result of stage k).
package hazard_ctrl_pkg;

  // Entry dst field is sized for the widest supported register file (256 regs).
  localparam int HAZ_DST_W = 8;
  localparam int FWD_SEL_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [HAZ_DST_W-1:0] dst;
    logic                 wr;
    logic                 load;
  } HazEntry;

  typedef logic [FWD_SEL_W-1:0] FwdSel;

  localparam FwdSel FWD_RF = '0;

  function automatic FwdSel fwd_stage(input int k);
    return FwdSel'(k + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side bundle between the pipeline and hazard_ctrl: decode operands and
// redirect in, forwarding selects, stall/flush controls and stall statistics out.
interface hazard_ctrl_if #(
  parameter int NUM_SRC = 2,
  parameter int ADDR_W  = 5,
  parameter int FWD_W   = 2,
  parameter int CNT_W   = 16
);
  logic                             d_valid;
  logic [NUM_SRC-1:0][ADDR_W-1:0]   d_src;
  logic [NUM_SRC-1:0]               d_src_used;
  logic [ADDR_W-1:0]                d_dst;
  logic                             d_wr;
  logic                             d_load;
  logic                             redirect;
  logic [NUM_SRC-1:0][FWD_W-1:0]    fwd_sel;
  logic                             stall_if;
  logic                             stall_d;
  logic                             flush_fd;
  logic                             flush_dx;
  logic [CNT_W-1:0]                 stall_cnt;

  modport master (
    output d_valid, d_src, d_src_used, d_dst, d_wr, d_load, redirect,
    input  fwd_sel, stall_if, stall_d, flush_fd, flush_dx, stall_cnt
  );

  modport slave (
    input  d_valid, d_src, d_src_used, d_dst, d_wr, d_load, redirect,
    output fwd_sel, stall_if, stall_d, flush_fd, flush_dx, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_src_match.sv
// Per-source hazard match: finds the youngest in-flight writer of one decode
// source register and flags a load-use hazard when that writer is a load in X.
module haz_src_match
  import hazard_ctrl_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 5,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    d_valid,
  input  logic [ADDR_W-1:0]       src,
  input  logic                    used,
  input  HazEntry [DEPTH-1:0]     entries,
  output logic                    hit,
  output logic [IDX_W-1:0]        hit_idx,
  output logic                    load_use
);

  logic hit_load;

  // Scan oldest to youngest so the lowest matching index is the one kept.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_load = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (d_valid && used && (src != '0) && entries[k].valid && entries[k].wr &&
          (entries[k].dst == HAZ_DST_W'(src))) begin
        hit      = 1'b1;
        hit_idx  = IDX_W'(k);
        hit_load = entries[k].load;
      end
    end
    load_use = hit && (hit_idx == '0) && hit_load;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection / forwarding controller: tracks DEPTH post-decode stages and
// drives forwarding selects, stalls and flushes. Forwarding enabled by HAZARD_FWD_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int BR_STAGE = 1,
  parameter int CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FWD_W  = $clog2(DEPTH + 1);

  HazEntry [DEPTH-1:0]            entry_q, entry_d;
  logic [CNT_W-1:0]               stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0]             hit, load_use;
  logic [NUM_SRC-1:0][IDX_W-1:0]  hit_idx;
  logic [NUM_SRC-1:0][FWD_W-1:0]  fwd_sel;
  logic                           stall_raw, stall;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    haz_src_match #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .IDX_W  (IDX_W)
    ) u_match (
      .d_valid  (bus.d_valid),
      .src      (bus.d_src[s]),
      .used     (bus.d_src_used[s]),
      .entries  (entry_q),
      .hit      (hit[s]),
      .hit_idx  (hit_idx[s]),
      .load_use (load_use[s])
    );
  end

`ifdef HAZARD_FWD_EN
  assign stall_raw = |load_use;

  always_comb begin
    fwd_sel = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (hit[s] && !load_use[s]) fwd_sel[s] = FWD_W'(fwd_stage(int'(hit_idx[s])));
      else                        fwd_sel[s] = FWD_W'(FWD_RF);
    end
  end
`else
  // Without forwarding, a reader waits until its writer has left every tracked stage.
  logic unused_fwd;
  assign unused_fwd = ^{hit_idx, load_use};
  assign stall_raw  = |hit;

  always_comb begin
    fwd_sel = '0;
    for (int s = 0; s < NUM_SRC; s++) fwd_sel[s] = FWD_W'(FWD_RF);
  end
`endif

  assign stall = stall_raw && !bus.redirect;

  assign bus.fwd_sel   = fwd_sel;
  assign bus.stall_d   = stall;
  assign bus.stall_if  = stall;
  assign bus.flush_fd  = bus.redirect;
  assign bus.flush_dx  = bus.redirect;
  assign bus.stall_cnt = stall_cnt_q;

  always_comb begin
    entry_d    = entry_q;
    entry_d[0] = '{valid: bus.d_valid && !stall && !bus.redirect,
                   dst:   HAZ_DST_W'(bus.d_dst),
                   wr:    bus.d_wr,
                   load:  bus.d_load};
    // Entries younger than the resolving branch are wrong-path and die as they shift.
    for (int k = 1; k < DEPTH; k++) begin
      entry_d[k] = entry_q[k-1];
      if (bus.redirect && ((k - 1) < BR_STAGE)) entry_d[k].valid = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      entry_q     <= entry_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations
// plus randomized decode traffic checked every cycle against an instruction-history model.
module tb_hazard_ctrl;

  localparam int NR = 32;
  localparam int NS = 2;
  localparam int DP = 3;
  localparam int BR = 1;
  localparam int AW = $clog2(NR);
  localparam int FW = $clog2(DP + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.NUM_SRC(NS), .ADDR_W(AW), .FWD_W(FW), .CNT_W(16)) bus ();
  hazard_ctrl_if #(.NUM_SRC(NS), .ADDR_W(AW), .FWD_W(FW), .CNT_W(4))  bus4 ();

  assign bus4.d_valid    = bus.d_valid;
  assign bus4.d_src      = bus.d_src;
  assign bus4.d_src_used = bus.d_src_used;
  assign bus4.d_dst      = bus.d_dst;
  assign bus4.d_wr       = bus.d_wr;
  assign bus4.d_load     = bus.d_load;
  assign bus4.redirect   = bus.redirect;

  hazard_ctrl #(.NUM_REGS(NR), .NUM_SRC(NS), .DEPTH(DP), .BR_STAGE(BR), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  hazard_ctrl #(.NUM_REGS(NR), .NUM_SRC(NS), .DEPTH(DP), .BR_STAGE(BR), .CNT_W(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  // Model: each instruction that entered X is recorded by the cycle it entered;
  // at cycle c, stage k holds the instruction that entered at c-1-k.
  typedef struct {
    bit live;
    int dst;
    bit wr;
    bit load;
  } ins_t;

  ins_t hist[int];
  int   cyc    = 0;
  int   m_fwd [NS];
  bit   m_stall;
  bit   m_flush;
  int   m_cnt  = 0;
  int   m_cnt4 = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   done   = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit at_stage(input int k, output ins_t e);
    e = '{0, 0, 0, 0};
    if (hist.exists(cyc - 1 - k)) begin
      e = hist[cyc - 1 - k];
      return e.live;
    end
    return 1'b0;
  endfunction

  function automatic void model_eval();
    bit   raw;
    int   hk;
    bit   hload;
    ins_t e;
    raw = 1'b0;
    for (int s = 0; s < NS; s++) begin
      hk       = -1;
      hload    = 1'b0;
      m_fwd[s] = 0;
      for (int k = 0; k < DP; k++) begin
        if (hk < 0 && at_stage(k, e) && e.wr && e.dst != 0 &&
            e.dst == int'(bus.d_src[s]) && bus.d_src_used[s] && bus.d_valid) begin
          hk    = k;
          hload = e.load;
        end
      end
`ifdef HAZARD_FWD_EN
      if (hk == 0 && hload) raw = 1'b1;
      else if (hk >= 0)     m_fwd[s] = hk + 1;
`else
      if (hk >= 0) raw = 1'b1;
`endif
    end
    m_stall = raw && !bus.redirect;
    m_flush = bus.redirect;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      m_cnt  = 0;
      m_cnt4 = 0;
    end else begin : upd
      ins_t e;
      model_eval();
      if (m_stall) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15)   m_cnt4++;
      end
      if (bus.redirect)
        for (int k = 0; k < BR; k++)
          if (hist.exists(cyc - 1 - k)) hist[cyc - 1 - k].live = 1'b0;
      e.live = bus.d_valid && !m_stall && !bus.redirect;
      e.dst  = int'(bus.d_dst);
      e.wr   = bus.d_wr;
      e.load = bus.d_load;
      hist[cyc] = e;
      if (hist.exists(cyc - DP - 1)) hist.delete(cyc - DP - 1);
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      model_eval();
      for (int s = 0; s < NS; s++)
        chk($sformatf("fwd_sel[%0d]", s), longint'(bus.fwd_sel[s]), m_fwd[s]);
      chk("stall_d",    bus.stall_d,    m_stall);
      chk("stall_if",   bus.stall_if,   m_stall);
      chk("flush_fd",   bus.flush_fd,   m_flush);
      chk("flush_dx",   bus.flush_dx,   m_flush);
      chk("stall_cnt",  bus.stall_cnt,  m_cnt);
      chk("stall_cnt4", bus4.stall_cnt, m_cnt4);
      chk("stall_d4",   bus4.stall_d,   m_stall);
    end
  end

  task automatic set_dec(input bit v, input int s0, input int s1, input bit [1:0] used,
                         input int dst, input bit wr, input bit ld, input bit rd);
    bus.d_valid    = v;
    bus.d_src[0]   = AW'(s0);
    bus.d_src[1]   = AW'(s1);
    bus.d_src_used = used;
    bus.d_dst      = AW'(dst);
    bus.d_wr       = wr;
    bus.d_load     = ld;
    bus.redirect   = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_dec(0, 0, 0, 2'b00, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  initial begin
    set_dec(0, 0, 0, 2'b00, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    mid();
    chk("rst_fwd0",  bus.fwd_sel[0], 0);
    chk("rst_stall", bus.stall_d,    0);
    chk("rst_cnt",   bus.stall_cnt,  0);
    tick();

    // Load-use: lw r5 in X, decode reads rt=r5
    set_dec(1, 0, 0, 2'b00, 5, 1, 1, 0); tick();
    set_dec(1, 1, 5, 2'b10, 6, 1, 0, 0);
    mid();
    chk("lu_stall_d",  bus.stall_d,  1);
    chk("lu_stall_if", bus.stall_if, 1);
    tick();
    mid();
`ifdef HAZARD_FWD_EN
    chk("lu_fwd1_m",   bus.fwd_sel[1], 2);
    chk("lu_stall_rl", bus.stall_d,    0);
    chk("lu_cnt",      bus.stall_cnt,  1);
`else
    chk("lu_stall_m",  bus.stall_d,    1);
    chk("lu_fwd1_rf",  bus.fwd_sel[1], 0);
`endif
    tick();
    idle(4);

    // Back-to-back ALU dependency: add r3 in X, decode reads rs=r3
    set_dec(1, 0, 0, 2'b00, 3, 1, 0, 0); tick();
    set_dec(1, 3, 0, 2'b01, 7, 1, 0, 0);
    mid();
`ifdef HAZARD_FWD_EN
    chk("alu_fwd0_x", bus.fwd_sel[0], 1);
    chk("alu_stall",  bus.stall_d,    0);
    tick();
    set_dec(1, 3, 0, 2'b01, 8, 1, 0, 0);
    mid();
    chk("alu_fwd0_m", bus.fwd_sel[0], 2);
    tick();
`else
    chk("alu_stall_x", bus.stall_d,    1);
    chk("alu_fwd0_rf", bus.fwd_sel[0], 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      mid();
      chk("alu_stall_hold", bus.stall_d, 1);
    end
    tick();
    mid();
    chk("alu_stall_done", bus.stall_d, 0);
    tick();
`endif
    idle(4);

    // Register zero never matches
    set_dec(1, 0, 0, 2'b00, 0, 1, 0, 0); tick();
    set_dec(1, 0, 0, 2'b01, 9, 1, 0, 0);
    mid();
    chk("r0_fwd0",  bus.fwd_sel[0], 0);
    chk("r0_stall", bus.stall_d,    0);
    tick();
    idle(4);

    // Redirect during a load-use hazard
    set_dec(1, 0, 0, 2'b00, 5, 1, 1, 0); tick();
    set_dec(1, 0, 5, 2'b10, 6, 1, 0, 1);
    mid();
    chk("rd_flush_fd", bus.flush_fd, 1);
    chk("rd_flush_dx", bus.flush_dx, 1);
    chk("rd_stall_d",  bus.stall_d,  0);
    chk("rd_stall_if", bus.stall_if, 0);
    tick();
    set_dec(1, 0, 5, 2'b10, 6, 1, 0, 0);
    mid();
    chk("rd_fwd1_sq",  bus.fwd_sel[1], 0);
    chk("rd_stall_sq", bus.stall_d,    0);
    chk("rd_flush_rl", bus.flush_fd,   0);
    tick();
    idle(4);

    // Asynchronous reset in the middle of a stall
    set_dec(1, 0, 0, 2'b00, 5, 1, 1, 0); tick();
    set_dec(1, 0, 5, 2'b10, 6, 1, 0, 0);
    mid();
    chk("ar_stall_pre", bus.stall_d, 1);
    rst = 1'b1;
    #1;
    chk("ar_stall_d",  bus.stall_d,    0);
    chk("ar_stall_if", bus.stall_if,   0);
    chk("ar_fwd1",     bus.fwd_sel[1], 0);
    chk("ar_cnt",      bus.stall_cnt,  0);
    chk("ar_cnt4",     bus4.stall_cnt, 0);
    tick();
    rst = 1'b0;
    idle(3);

    // Twenty single load-use stalls: 16-bit counter reads 20, 4-bit one pins at 15
    for (int i = 0; i < 20; i++) begin
      set_dec(1, 0, 0, 2'b00, 5, 1, 1, 0); tick();
      set_dec(1, 0, 5, 2'b10, 6, 1, 0, 0); tick();
    end
    set_dec(0, 0, 0, 2'b00, 0, 0, 0, 0);
    mid();
    chk("sat_cnt4",  bus4.stall_cnt, 15);
    chk("sat_cnt16", bus.stall_cnt,  20);
    tick();
    idle(4);

    // Randomized decode traffic over a small register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      set_dec($urandom_range(0, 9) != 0,
              $urandom_range(0, 3), $urandom_range(0, 3),
              2'($urandom_range(0, 3)),
              $urandom_range(0, 3),
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 9) == 0);
      tick();
    end
    rst = 1'b0;
    idle(2);

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
